// File: rtl/ulpb_sleep_ctrl.sv
// Always-on power sequencer for the layer domain.
// Stages power, clock, isolation and reset on wake; reverses them on sleep.
module ulpb_sleep_ctrl #(
    parameter logic                 HOLD      = 1'b1,
    parameter logic                 RELEASE   = 1'b0,
    parameter int                   DLY_WIDTH = 4,
    parameter logic [DLY_WIDTH-1:0] PWR_DLY   = 4'd8,
    parameter logic [DLY_WIDTH-1:0] CLK_DLY   = 4'd2,
    parameter logic [DLY_WIDTH-1:0] ISO_DLY   = 4'd2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic WAKEUP_REQ,
    input  logic SLEEP_REQ,
    output logic POWER_ON,
    output logic RELEASE_CLK,
    output logic RELEASE_ISO,
    output logic RELEASE_RST,
    output logic AWAKE,
    output logic BUSY
);

    localparam logic [2:0] S_ASLEEP = 3'd0;
    localparam logic [2:0] S_PWR_UP = 3'd1;
    localparam logic [2:0] S_CLK_UP = 3'd2;
    localparam logic [2:0] S_ISO_UP = 3'd3;
    localparam logic [2:0] S_AWAKE  = 3'd4;
    localparam logic [2:0] S_RST_DN = 3'd5;
    localparam logic [2:0] S_ISO_DN = 3'd6;
    localparam logic [2:0] S_CLK_DN = 3'd7;

    localparam logic [DLY_WIDTH-1:0] ONE  = 1;
    localparam logic [DLY_WIDTH-1:0] ZERO = '0;

    // A zero dwell behaves as one cycle, so the counter loads DLY-1 floored at 0.
    function automatic logic [DLY_WIDTH-1:0] dwell(
        input logic [DLY_WIDTH-1:0] d
    );
        return (d == ZERO) ? ZERO : d - ONE;
    endfunction

    logic [2:0]           state_q, state_d;
    logic [DLY_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pwr_q, pwr_d;
    logic                 clk_q, clk_d;
    logic                 iso_q, iso_d;
    logic                 rst_q, rst_d;
    logic                 awake_q, awake_d;
    logic                 busy_q, busy_d;
    logic                 expired;

    assign expired = (cnt_q == ZERO);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pwr_d   = pwr_q;
        clk_d   = clk_q;
        iso_d   = iso_q;
        rst_d   = rst_q;
        case (state_q)
            S_ASLEEP: begin
                if (WAKEUP_REQ) begin
                    pwr_d   = RELEASE;
                    cnt_d   = dwell(PWR_DLY);
                    state_d = S_PWR_UP;
                end
            end
            S_PWR_UP: begin
                if (!expired) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    clk_d   = RELEASE;
                    cnt_d   = dwell(CLK_DLY);
                    state_d = S_CLK_UP;
                end
            end
            S_CLK_UP: begin
                if (!expired) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    iso_d   = RELEASE;
                    cnt_d   = dwell(ISO_DLY);
                    state_d = S_ISO_UP;
                end
            end
            S_ISO_UP: begin
                if (!expired) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    rst_d   = RELEASE;
                    state_d = S_AWAKE;
                end
            end
            S_AWAKE: begin
                // A concurrent wake request keeps the layer up.
                if (SLEEP_REQ && !WAKEUP_REQ) begin
                    rst_d   = HOLD;
                    cnt_d   = dwell(ISO_DLY);
                    state_d = S_RST_DN;
                end
            end
            S_RST_DN: begin
                if (!expired) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    iso_d   = HOLD;
                    cnt_d   = dwell(CLK_DLY);
                    state_d = S_ISO_DN;
                end
            end
            S_ISO_DN: begin
                if (!expired) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    clk_d   = HOLD;
                    cnt_d   = dwell(PWR_DLY);
                    state_d = S_CLK_DN;
                end
            end
            S_CLK_DN: begin
                if (!expired) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    pwr_d   = HOLD;
                    state_d = S_ASLEEP;
                end
            end
            default: begin
                state_d = S_ASLEEP;
                cnt_d   = ZERO;
                pwr_d   = HOLD;
                clk_d   = HOLD;
                iso_d   = HOLD;
                rst_d   = HOLD;
            end
        endcase
        awake_d = (state_d == S_AWAKE);
        busy_d  = (state_d != S_AWAKE) && (state_d != S_ASLEEP);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_ASLEEP;
            cnt_q   <= ZERO;
            pwr_q   <= HOLD;
            clk_q   <= HOLD;
            iso_q   <= HOLD;
            rst_q   <= HOLD;
            awake_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwr_q   <= pwr_d;
            clk_q   <= clk_d;
            iso_q   <= iso_d;
            rst_q   <= rst_d;
            awake_q <= awake_d;
            busy_q  <= busy_d;
        end
    end

    assign POWER_ON    = pwr_q;
    assign RELEASE_CLK = clk_q;
    assign RELEASE_ISO = iso_q;
    assign RELEASE_RST = rst_q;
    assign AWAKE       = awake_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_ulpb_sleep_ctrl.sv
// Directed bench for ulpb_sleep_ctrl: default-timing and fast instances.
// Observed vector is {POWER_ON, RELEASE_CLK, RELEASE_ISO, RELEASE_RST, AWAKE, BUSY}.
module tb_ulpb_sleep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, wake = 1'b0, sleep = 1'b0;
    logic po, rc, ri, rr, aw, bz;
    logic rst2 = 1'b1, wake2 = 1'b0, sleep2 = 1'b0;
    logic po2, rc2, ri2, rr2, aw2, bz2;

    int vectors = 0;
    int miscompares = 0;

    ulpb_sleep_ctrl u_dut (
        .CLK(clk), .RESET(rst), .WAKEUP_REQ(wake), .SLEEP_REQ(sleep),
        .POWER_ON(po), .RELEASE_CLK(rc), .RELEASE_ISO(ri),
        .RELEASE_RST(rr), .AWAKE(aw), .BUSY(bz)
    );

    ulpb_sleep_ctrl #(
        .PWR_DLY(4'd0), .CLK_DLY(4'd0), .ISO_DLY(4'd1)
    ) u_fast (
        .CLK(clk), .RESET(rst2), .WAKEUP_REQ(wake2), .SLEEP_REQ(sleep2),
        .POWER_ON(po2), .RELEASE_CLK(rc2), .RELEASE_ISO(ri2),
        .RELEASE_RST(rr2), .AWAKE(aw2), .BUSY(bz2)
    );

    function automatic logic [5:0] obs();
        return {po, rc, ri, rr, aw, bz};
    endfunction

    function automatic logic [5:0] obs2();
        return {po2, rc2, ri2, rr2, aw2, bz2};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wake = 1'b0;
        sleep = 1'b0;
        step();
        step();
        vectors++;
        if (obs() !== 6'b111100) begin
            miscompares++;
            $display("FAIL reset: got %b expected %b", obs(), 6'b111100);
        end
        rst = 1'b0;
    endtask

    task automatic test_wake(input bit keep, input bit poke);
        logic [5:0] exp;
        wake = 1'b1;
        sleep = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            step();
            exp = {1'b0, e < 9, e < 11, e < 13, e >= 13, e < 13};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL wake edge %0d: got %b expected %b",
                         e, obs(), exp);
            end
            if (e == 1 && !keep) wake = 1'b0;
            if (poke && e == 2) sleep = 1'b1;
            if (poke && e == 3) sleep = 1'b0;
        end
    endtask

    task automatic test_sleep(input bit hold_wake);
        logic [5:0] exp;
        wake = 1'b0;
        sleep = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (e <= 13)
                exp = {e >= 13, e >= 5, e >= 3, 1'b1, 1'b0, e < 13};
            else
                exp = hold_wake ? 6'b011101 : 6'b111100;
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL sleep edge %0d: got %b expected %b",
                         e, obs(), exp);
            end
            if (e == 1) begin
                sleep = 1'b0;
                wake = hold_wake;
            end
        end
        wake = 1'b0;
    endtask

    task automatic test_both_awake();
        wake = 1'b1;
        sleep = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            vectors++;
            if (obs() !== 6'b000010) begin
                miscompares++;
                $display("FAIL both_req edge %0d: got %b expected %b",
                         e, obs(), 6'b000010);
            end
        end
        wake = 1'b0;
        sleep = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        wake = 1'b0;
        sleep = 1'b0;
        step();
        rst = 1'b0;
        wake = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            step();
            if (e == 1) wake = 1'b0;
        end
        vectors++;
        if (obs() !== 6'b000101) begin
            miscompares++;
            $display("FAIL iso_up: got %b expected %b", obs(), 6'b000101);
        end
        rst = 1'b1;
        step();
        vectors++;
        if (obs() !== 6'b111100) begin
            miscompares++;
            $display("FAIL reset_mid: got %b expected %b", obs(), 6'b111100);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (obs() !== 6'b111100) begin
            miscompares++;
            $display("FAIL post_reset: got %b expected %b", obs(), 6'b111100);
        end
    endtask

    task automatic test_fast();
        logic [5:0] exp;
        logic [3:0] prev, cur;
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        wake2 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            exp = {1'b0, e < 2, e < 3, e < 4, e >= 4, e < 4};
            vectors++;
            if (obs2() !== exp) begin
                miscompares++;
                $display("FAIL fast edge %0d: got %b expected %b",
                         e, obs2(), exp);
            end
            if (e == 1) wake2 = 1'b0;
        end
        prev = {po2, rc2, ri2, rr2};
        for (int i = 0; i < 1000; i++) begin
            wake2 = ($urandom_range(0, 3) == 0);
            sleep2 = ($urandom_range(0, 2) == 0);
            step();
            cur = {po2, rc2, ri2, rr2};
            vectors++;
            if ((!rr2 && ri2) || (!ri2 && rc2) || (!rc2 && po2) ||
                ($countones(prev ^ cur) > 1)) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %b previous %b",
                         i, cur, prev);
            end
            prev = cur;
        end
        wake2 = 1'b0;
        sleep2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wake(1'b0, 1'b0);
        test_sleep(1'b0);
        test_wake(1'b0, 1'b0);
        test_both_awake();
        test_sleep(1'b0);
        test_wake(1'b1, 1'b1);
        test_sleep(1'b1);
        test_reset_mid();
        test_fast();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
